// File: rtl/sram_wb_bank_ctrl.sv
// Wishbone slave front-end for NUM_BANKS single-port 32-bit SRAM macro banks.
// Handles one transfer at a time: decode, strobe the macro, wait out read latency, then ack.
module sram_wb_bank_ctrl #(
    parameter int unsigned NUM_BANKS    = 2,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [NUM_BANKS-1:0]      sram_en_o,
    output logic [3:0]                sram_we_o,
    output logic [ADDR_WIDTH-1:0]     sram_addr_o,
    output logic [31:0]               sram_din_o,
    input  logic [NUM_BANKS*32-1:0]   sram_dout_i,
    output logic                      oor_o
);

    localparam int unsigned BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned LAT_W      = 2;
    localparam logic [63:0] WORD_LIMIT = 64'(NUM_BANKS) << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

    typedef struct packed {
        logic              we;
        logic [BANK_W-1:0] bank;
        logic              hit;
    } req_t;

    state_e                  state_q, state_d;
    req_t                    req_q, req_d;
    logic [LAT_W-1:0]        cnt_q, cnt_d;
    logic                    ack_q, ack_d;
    logic [31:0]             dat_q, dat_d;
    logic [NUM_BANKS-1:0]    en_q, en_d;
    logic [3:0]              we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             din_q, din_d;
    logic                    oor_q, oor_d;

    logic [31:0]             word_c;
    logic                    hit_c;
    logic [BANK_W-1:0]       bank_c;
    logic [ADDR_WIDTH-1:0]   row_c;
    logic [NUM_BANKS-1:0]    bank_onehot_c;
    logic [31:0]             rd_bank_c;

    // Address decode; the subtraction wraps so addresses below the base fail the compare.
    assign word_c = (wbs_adr_i - BASE_ADDR) >> 2;
    assign hit_c  = (wbs_adr_i >= BASE_ADDR) && (64'(word_c) < WORD_LIMIT);
    assign bank_c = BANK_W'(word_c >> ADDR_WIDTH);
    assign row_c  = word_c[ADDR_WIDTH-1:0];

    always_comb begin
        bank_onehot_c = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (bank_c == BANK_W'(b)) bank_onehot_c[b] = 1'b1;
        end
    end

    // Read-data select for the bank latched with the request.
    always_comb begin
        rd_bank_c = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (req_q.bank == BANK_W'(b)) rd_bank_c = sram_dout_i[32*b +: 32];
        end
    end

    // Next-state and next-output logic; strobes are computed one cycle ahead so they land in ISSUE.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        en_d    = '0;
        we_d    = '0;
        addr_d  = addr_q;
        din_d   = din_q;
        oor_d   = oor_q;
        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    req_d.we   = wbs_we_i;
                    req_d.bank = bank_c;
                    req_d.hit  = hit_c;
                    addr_d     = row_c;
                    if (wbs_we_i) din_d = wbs_dat_i;
                    if (hit_c && (!wbs_we_i || (wbs_sel_i != 4'h0))) en_d = bank_onehot_c;
                    if (hit_c && wbs_we_i) we_d = wbs_sel_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (req_q.hit && !req_q.we) begin
                    cnt_d   = LAT_W'(READ_LATENCY);
                    state_d = WAIT;
                end else begin
                    ack_d   = 1'b1;
                    state_d = ACK;
                    if (!req_q.hit) begin
                        oor_d = 1'b1;
                        if (!req_q.we) dat_d = 32'h0;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAT_W'(1)) begin
                    dat_d   = rd_bank_c;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            en_q    <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            oor_q   <= oor_d;
        end
    end

    // A master that drops cyc mid-transfer never sees the ack.
    assign wbs_ack_o   = ack_q & wbs_cyc_i;
    assign wbs_dat_o   = dat_q;
    assign sram_en_o   = en_q;
    assign sram_we_o   = we_q;
    assign sram_addr_o = addr_q;
    assign sram_din_o  = din_q;
    assign oor_o       = oor_q;

endmodule

// File: tb/tb_sram_wb_bank_ctrl.sv
// Bench for sram_wb_bank_ctrl: two instances (read latency 1 and 3) with SRAM macro models,
// driven by directed and random transfers and compared against a word-addressed memory model.
module tb_sram_wb_bank_ctrl;

    localparam int NB    = 2;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk;
    logic              rst_n [2];
    logic              cyc   [2];
    logic              stb   [2];
    logic              we    [2];
    logic [3:0]        sel   [2];
    logic [31:0]       adr   [2];
    logic [31:0]       dat_w [2];
    logic              ack   [2];
    logic [31:0]       dat_r [2];
    logic [NB-1:0]     en    [2];
    logic [3:0]        swe   [2];
    logic [AW-1:0]     saddr [2];
    logic [31:0]       sdin  [2];
    logic [NB*32-1:0]  sdout [2];
    logic              oor   [2];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_mem [int];
    logic        exp_oor [2];
    logic [31:0] last_rd [2];

    sram_wb_bank_ctrl #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_LATENCY(1)) u_dut_l1 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n[0]),
        .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]), .wbs_sel_i(sel[0]),
        .wbs_adr_i(adr[0]), .wbs_dat_i(dat_w[0]), .wbs_ack_o(ack[0]), .wbs_dat_o(dat_r[0]),
        .sram_en_o(en[0]), .sram_we_o(swe[0]), .sram_addr_o(saddr[0]), .sram_din_o(sdin[0]),
        .sram_dout_i(sdout[0]), .oor_o(oor[0])
    );

    sram_wb_bank_ctrl #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_LATENCY(3)) u_dut_l3 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n[1]),
        .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]), .wbs_sel_i(sel[1]),
        .wbs_adr_i(adr[1]), .wbs_dat_i(dat_w[1]), .wbs_ack_o(ack[1]), .wbs_dat_o(dat_r[1]),
        .sram_en_o(en[1]), .sram_we_o(swe[1]), .sram_addr_o(saddr[1]), .sram_din_o(sdin[1]),
        .sram_dout_i(sdout[1]), .oor_o(oor[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up contents of every macro word, indexed by instance and global word number.
    function automatic logic [31:0] init_val(input int i, input int w);
        return (32'(w) * 32'h9E37_79B1) ^ (32'(i) << 28) ^ 32'h0BAD_F00D;
    endfunction

    // SRAM macro models: byte-write on enable, read data valid only in the latency cycle.
    logic [31:0] macro_mem [2][NB][DEPTH];
    bit          macro_wr  [2][NB][DEPTH];
    logic [31:0] pipe      [2][NB][3];

    always @(posedge clk) begin : macro_model
        logic [31:0] cur;
        logic [31:0] nxt;
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < NB; b++) begin
                cur = macro_wr[i][b][saddr[i]] ? macro_mem[i][b][saddr[i]]
                                              : init_val(i, b * DEPTH + int'(saddr[i]));
                pipe[i][b][1] <= pipe[i][b][0];
                pipe[i][b][2] <= pipe[i][b][1];
                if (en[i][b] && (swe[i] == 4'h0)) pipe[i][b][0] <= cur;
                else                               pipe[i][b][0] <= $urandom;
                if (en[i][b] && (swe[i] != 4'h0)) begin
                    nxt = cur;
                    for (int k = 0; k < 4; k++) begin
                        if (swe[i][k]) nxt[8*k +: 8] = sdin[i][8*k +: 8];
                    end
                    macro_mem[i][b][saddr[i]] <= nxt;
                    macro_wr[i][b][saddr[i]]  <= 1'b1;
                end
            end
        end
    end

    assign sdout[0] = {pipe[0][1][0], pipe[0][0][0]};
    assign sdout[1] = {pipe[1][1][2], pipe[1][0][2]};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One Wishbone transfer on instance i; expectations come from the address map and memory model.
    task automatic xfer(input int i, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit drop);
        logic [31:0]   word;
        logic [31:0]   old;
        logic [31:0]   exp_rd;
        logic [NB-1:0] exp_en;
        bit            hit;
        bit            strobe;
        int            bank, row, lat, exp_ack, ack_at, strobes, key;
        lat     = (i == 0) ? 1 : 3;
        word    = (a - BASE) >> 2;
        hit     = (a >= BASE) && (word < 32'(NB * DEPTH));
        bank    = hit ? int'(word) / DEPTH : 0;
        row     = hit ? int'(word) % DEPTH : 0;
        key     = i * 4096 + (hit ? int'(word) : 0);
        strobe  = hit && (!w || (s != 4'h0));
        exp_ack = (hit && !w) ? 2 + lat : 2;
        exp_en  = strobe ? NB'(1 << bank) : '0;

        @(negedge clk);
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; sel[i] = s; adr[i] = a; dat_w[i] = d;
        ack_at  = 0;
        strobes = 0;
        for (int c = 1; c <= exp_ack; c++) begin
            @(negedge clk);
            if ((en[i] != '0) || (swe[i] != 4'h0)) strobes++;
            if (c == 1) begin
                check("en_c1", 64'(en[i]), 64'(exp_en));
                check("we_c1", 64'(swe[i]), 64'((strobe && w) ? s : 4'h0));
                if (strobe)     check("addr_c1", 64'(saddr[i]), 64'(row));
                if (strobe && w) check("din_c1", 64'(sdin[i]), 64'(d));
                if (drop) begin cyc[i] = 1'b0; stb[i] = 1'b0; end
            end
            if (ack[i] && (ack_at == 0)) ack_at = c;
            if ((c == exp_ack) || ack[i]) begin cyc[i] = 1'b0; stb[i] = 1'b0; end
        end
        check("strobe_cycles", 64'(strobes), strobe ? 64'd1 : 64'd0);
        check("ack_cycle", 64'(ack_at), drop ? 64'd0 : 64'(exp_ack));

        if (!w) begin
            if (hit) exp_rd = ref_mem.exists(key) ? ref_mem[key] : init_val(i, int'(word));
            else     exp_rd = 32'h0;
            last_rd[i] = exp_rd;
        end else if (strobe) begin
            old = ref_mem.exists(key) ? ref_mem[key] : init_val(i, int'(word));
            for (int k = 0; k < 4; k++) begin
                if (s[k]) old[8*k +: 8] = d[8*k +: 8];
            end
            ref_mem[key] = old;
        end
        if (!hit) exp_oor[i] = 1'b1;
        check("rdata", 64'(dat_r[i]), 64'(last_rd[i]));
        check("oor", 64'(oor[i]), 64'(exp_oor[i]));
    endtask

    task automatic check_reset_state(input int i);
        check("rst_ctl", 64'({ack[i], en[i], swe[i], oor[i]}), 64'd0);
        check("rst_rdata", 64'(dat_r[i]), 64'd0);
        check("rst_addr", 64'(saddr[i]), 64'd0);
        check("rst_din", 64'(sdin[i]), 64'd0);
    endtask

    // Reset asserted in cycle 1 of a read: outputs clear at once and the read is lost.
    task automatic reset_mid_read(input int i, input logic [31:0] a);
        int acks;
        @(negedge clk);
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = 1'b0; sel[i] = 4'hF; adr[i] = a;
        @(negedge clk);
        rst_n[i] = 1'b0;
        #1;
        check_reset_state(i);
        cyc[i] = 1'b0; stb[i] = 1'b0;
        @(negedge clk);
        rst_n[i] = 1'b1;
        exp_oor[i] = 1'b0;
        last_rd[i] = 32'h0;
        acks = 0;
        cyc[i] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack[i] || (en[i] != '0)) acks++;
        end
        cyc[i] = 1'b0;
        check("no_ack_after_reset", 64'(acks), 64'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        int unsigned row;
        logic [31:0] lo;
        r  = $urandom_range(0, 9);
        lo = 32'($urandom_range(0, 3));
        if (r <= 6) begin
            row = $urandom_range(0, 15);
            if (row >= 8) row = row + 32'(DEPTH - 16);
            return BASE + 32'(($urandom_range(0, NB - 1) * DEPTH + row) * 4) + lo;
        end else if (r == 7) begin
            return BASE + 32'(NB * DEPTH * 4) + 32'($urandom_range(0, 15) * 4) + lo;
        end else if (r == 8) begin
            return BASE - 32'($urandom_range(1, 16) * 4) + lo;
        end
        return $urandom;
    endfunction

    initial begin : watchdog
        #400_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            sel[i] = 4'h0; adr[i] = 32'h0; dat_w[i] = 32'h0;
            exp_oor[i] = 1'b0; last_rd[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        for (int i = 0; i < 2; i++) begin
            xfer(i, 1'b1, 32'h3000_1008, 4'hF, 32'hA5A5_1234, 1'b0);
            xfer(i, 1'b1, 32'h3000_0004, 4'hF, 32'h1122_3344, 1'b0);
            xfer(i, 1'b0, 32'h3000_0004, 4'hF, 32'h0,         1'b0);
            xfer(i, 1'b1, 32'h3000_0000, 4'b0100, 32'hDEAD_BEEF, 1'b0);
            xfer(i, 1'b0, 32'h3000_0000, 4'hF, 32'h0,         1'b0);
            xfer(i, 1'b1, 32'h3000_0000, 4'h0, 32'h5555_5555, 1'b0);
            xfer(i, 1'b0, 32'h3000_0000, 4'hF, 32'h0,         1'b0);
            xfer(i, 1'b0, 32'h3000_2000, 4'hF, 32'h0,         1'b0);
            xfer(i, 1'b1, 32'h2FFF_FFFC, 4'hF, 32'h7777_7777, 1'b0);
            xfer(i, 1'b0, 32'h3000_1008, 4'hF, 32'h0,         1'b0);
            xfer(i, 1'b1, 32'h3000_0010, 4'hF, 32'hC0FF_EE01, 1'b1);
            xfer(i, 1'b0, 32'h3000_0010, 4'hF, 32'h0,         1'b0);
            reset_mid_read(i, 32'h3000_1008);
            xfer(i, 1'b0, 32'h3000_1008, 4'hF, 32'h0,         1'b0);
        end

        for (int n = 0; n < 300; n++) begin
            int          i;
            logic [3:0]  s;
            i = n % 2;
            s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            xfer(i, 1'($urandom_range(0, 1)), rand_addr(), s, $urandom,
                 $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
